// File: rtl/vtc_ce_fix.sv
// Video-timing clock-enable fixer: measures the active-line length and masks
// vtg_ce for a short window once per frame at a line/offset relative to line end.
module vtc_ce_fix #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIX_LENGTH = 4,
  parameter int unsigned FIX_LINE   = 7,
  parameter int unsigned FIX_OFFSET = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  input  logic             av_in,
  input  logic             hb_in,
  input  logic             hs_in,
  input  logic             vb_in,
  input  logic             vs_in,
  input  logic             vtg_ce_in,
  output logic             av_out,
  output logic             hb_out,
  output logic             hs_out,
  output logic             vb_out,
  output logic             vs_out,
  output logic             vtg_ce_out,
  output logic [CNT_W-1:0] line_len,
  output logic             locked,
  output logic             fix_done
);

  localparam int unsigned GCNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t             state_q, state_d;
  logic [GCNT_W-1:0]  gcnt_q, gcnt_d;
  logic               gate_q, gate_d;
  logic               fix_done_q, fix_done_d;
  logic [CNT_W-1:0]   hb_cnt_q, hb_cnt_d;
  logic [CNT_W-1:0]   line_len_q, line_len_d;
  logic               locked_q, locked_d;
  logic [CNT_W-1:0]   vline_q, vline_d;
  logic               hb_d_q;
  logic               hb_rise;
  logic [CNT_W-1:0]   tgt;
  logic               trig;

  assign av_out     = av_in;
  assign hb_out     = hb_in;
  assign hs_out     = hs_in;
  assign vb_out     = vb_in;
  assign vs_out     = vs_in;
  assign vtg_ce_out = vtg_ce_in & ~gate_q;
  assign line_len   = line_len_q;
  assign locked     = locked_q;
  assign fix_done   = fix_done_q;

  // Line measurement, line counting and trigger match.
  always_comb begin
    hb_rise    = hb_in & ~hb_d_q;
    hb_cnt_d   = hb_cnt_q;
    line_len_d = line_len_q;
    locked_d   = locked_q;
    vline_d    = vline_q;
    tgt        = '0;

    if (hb_in) begin
      hb_cnt_d = '0;
    end else if (hb_cnt_q != CNT_MAX) begin
      hb_cnt_d = hb_cnt_q + CNT_W'(1);
    end

    if (hb_rise) begin
      line_len_d = hb_cnt_q;
      locked_d   = (hb_cnt_q == line_len_q) && (hb_cnt_q != '0);
    end

    if (vs_in) begin
      vline_d = '0;
    end else if (hb_rise && (vline_q != CNT_MAX)) begin
      vline_d = vline_q + CNT_W'(1);
    end

    // Guarded so a large offset on a short line clamps to 0 instead of wrapping.
    if (32'(line_len_q) > FIX_OFFSET) begin
      tgt = line_len_q - CNT_W'(FIX_OFFSET);
    end

    trig = en & locked_q & ~hb_in & (32'(vline_q) == FIX_LINE) & (hb_cnt_q == tgt);
  end

  // Gate sequencing: disable beats vsync, vsync beats trigger.
  always_comb begin
    state_d    = state_q;
    gcnt_d     = gcnt_q;
    gate_d     = gate_q;
    fix_done_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      gate_d  = 1'b0;
      gcnt_d  = '0;
    end else if (vs_in) begin
      state_d = ARM;
      gate_d  = 1'b0;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        ARM: begin
          if (trig) begin
            state_d = GATE;
            gcnt_d  = GCNT_W'(FIX_LENGTH - 1);
            gate_d  = 1'b1;
          end
        end
        GATE: begin
          if (gcnt_q == '0) begin
            state_d    = DONE;
            gate_d     = 1'b0;
            fix_done_d = 1'b1;
          end else begin
            gcnt_d = gcnt_q - GCNT_W'(1);
          end
        end
        IDLE, DONE: state_d = state_q;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gcnt_q     <= '0;
      gate_q     <= 1'b0;
      fix_done_q <= 1'b0;
      hb_cnt_q   <= '0;
      line_len_q <= '0;
      locked_q   <= 1'b0;
      vline_q    <= '0;
      hb_d_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gcnt_q     <= gcnt_d;
      gate_q     <= gate_d;
      fix_done_q <= fix_done_d;
      hb_cnt_q   <= hb_cnt_d;
      line_len_q <= line_len_d;
      locked_q   <= locked_d;
      vline_q    <= vline_d;
      hb_d_q     <= hb_in;
    end
  end

endmodule

// File: tb/tb_vtc_ce_fix.sv
// Bench for vtc_ce_fix: three parameterisations driven by one timing stream and
// compared every cycle against a frame-level behavioural model.
module tb_vtc_ce_fix;

  localparam int FL  = 4;
  localparam int FLN = 7;

  logic pclk = 1'b0;
  logic rst = 1'b1, en = 1'b0;
  logic av_in = 1'b0, hb_in = 1'b0, hs_in = 1'b0, vb_in = 1'b0, vs_in = 1'b0;
  logic vtg_ce_in = 1'b1;
  logic [2:0] av_o, hb_o, hs_o, vb_o, vs_o, ce_o, lk_o, fd_o;
  logic [15:0] ll0, ll1;
  logic [4:0]  ll2;

  always #5 pclk = ~pclk;

  vtc_ce_fix u0 (
    .pclk(pclk), .rst(rst), .en(en), .av_in(av_in), .hb_in(hb_in), .hs_in(hs_in),
    .vb_in(vb_in), .vs_in(vs_in), .vtg_ce_in(vtg_ce_in),
    .av_out(av_o[0]), .hb_out(hb_o[0]), .hs_out(hs_o[0]), .vb_out(vb_o[0]), .vs_out(vs_o[0]),
    .vtg_ce_out(ce_o[0]), .line_len(ll0), .locked(lk_o[0]), .fix_done(fd_o[0]));

  vtc_ce_fix #(.FIX_OFFSET(200)) u1 (
    .pclk(pclk), .rst(rst), .en(en), .av_in(av_in), .hb_in(hb_in), .hs_in(hs_in),
    .vb_in(vb_in), .vs_in(vs_in), .vtg_ce_in(vtg_ce_in),
    .av_out(av_o[1]), .hb_out(hb_o[1]), .hs_out(hs_o[1]), .vb_out(vb_o[1]), .vs_out(vs_o[1]),
    .vtg_ce_out(ce_o[1]), .line_len(ll1), .locked(lk_o[1]), .fix_done(fd_o[1]));

  vtc_ce_fix #(.CNT_W(5)) u2 (
    .pclk(pclk), .rst(rst), .en(en), .av_in(av_in), .hb_in(hb_in), .hs_in(hs_in),
    .vb_in(vb_in), .vs_in(vs_in), .vtg_ce_in(vtg_ce_in),
    .av_out(av_o[2]), .hb_out(hb_o[2]), .hs_out(hs_o[2]), .vb_out(vb_o[2]), .vs_out(vs_o[2]),
    .vtg_ce_out(ce_o[2]), .line_len(ll2), .locked(lk_o[2]), .fix_done(fd_o[2]));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  int m_max [3] = '{65535, 65535, 31};
  int m_ofs [3] = '{2, 200, 2};
  int m_hbc [3], m_hbd [3], m_llen [3], m_lock [3], m_vl [3], m_arm [3], m_gl [3], m_done [3];

  bit en_v = 1'b1, rand_ce = 1'b0;
  int vsn = 3;
  int sp_line = -1, sp_vs_px = -1, sp_en_off = -1, sp_rst = -1;
  int px = 0, ln = 0;
  int lowc [3], donec [3], first [3], firstln [3];

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[u%0d] line=%0d px=%0d observed=%0d expected=%0d", tag, inst, ln, px, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hbc[i] = 0; m_hbd[i] = 0; m_llen[i] = 0; m_lock[i] = 0;
      m_vl[i] = 0; m_arm[i] = 0; m_gl[i] = 0; m_done[i] = 0;
    end
  endtask

  // One clock of the reference behaviour, using the inputs present at the edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int tgt;
      bit trig, rise;
      tgt  = (m_llen[i] > m_ofs[i]) ? m_llen[i] - m_ofs[i] : 0;
      trig = en && (m_lock[i] != 0) && !hb_in && (m_vl[i] == FLN) && (m_hbc[i] == tgt);
      rise = hb_in && (m_hbd[i] == 0);
      m_done[i] = 0;
      if (!en) begin
        m_arm[i] = 0; m_gl[i] = 0;
      end else if (vs_in) begin
        m_arm[i] = 1; m_gl[i] = 0;
      end else if (m_gl[i] > 0) begin
        m_gl[i]--;
        if (m_gl[i] == 0) m_done[i] = 1;
      end else if (m_arm[i] != 0 && trig) begin
        m_gl[i] = FL; m_arm[i] = 0;
      end
      if (rise) begin
        m_lock[i] = (m_hbc[i] == m_llen[i] && m_hbc[i] != 0) ? 1 : 0;
        m_llen[i] = m_hbc[i];
      end
      if (vs_in) m_vl[i] = 0;
      else if (rise && m_vl[i] < m_max[i]) m_vl[i]++;
      if (hb_in) m_hbc[i] = 0;
      else if (m_hbc[i] < m_max[i]) m_hbc[i]++;
      m_hbd[i] = hb_in ? 1 : 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ll;
      ll = (i == 0) ? 32'(ll0) : (i == 1) ? 32'(ll1) : 32'(ll2);
      chk("vtg_ce_out", i, 32'(ce_o[i]), 32'(vtg_ce_in & (m_gl[i] == 0)));
      chk("line_len", i, ll, 32'(m_llen[i]));
      chk("locked", i, 32'(lk_o[i]), 32'(m_lock[i]));
      chk("fix_done", i, 32'(fd_o[i]), 32'(m_done[i]));
      chk("pass", i, 32'({av_o[i], hb_o[i], hs_o[i], vb_o[i], vs_o[i]}),
          32'({av_in, hb_in, hs_in, vb_in, vs_in}));
    end
  endtask

  task automatic track();
    for (int i = 0; i < 3; i++) begin
      if (vtg_ce_in && !ce_o[i]) begin
        lowc[i]++;
        if (first[i] < 0) begin first[i] = px; firstln[i] = ln; end
      end
      if (fd_o[i]) donec[i]++;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      lowc[i] = 0; donec[i] = 0; first[i] = -1; firstln[i] = -1;
    end
  endtask

  task automatic cyc(input logic hb, input logic vs_v, input bit rst_pulse);
    @(negedge pclk);
    rst = 1'b0; en = en_v; hb_in = hb; vs_in = vs_v; av_in = ~hb;
    hs_in = 1'($urandom); vb_in = 1'($urandom);
    vtg_ce_in = rand_ce ? 1'(($urandom % 4) != 0) : 1'b1;
    #1;
    check_all();
    track();
    if (rst_pulse) begin
      #2; rst = 1'b1; #1;
      model_reset();
      check_all();
    end else begin
      model_step();
    end
  endtask

  task automatic frame(input int n, input int act_a, input int n_a, input int act_b, input int blk);
    for (int l = 0; l < n; l++) begin
      int act;
      act = (l < n_a) ? act_a : act_b;
      ln = l;
      for (int i = 0; i < act; i++) begin
        px = i;
        cyc(1'b0, 1'(l == sp_line && i == sp_vs_px), 1'b0);
      end
      for (int j = 0; j < blk; j++) begin
        px = act + j;
        if (l == sp_line && j == sp_en_off) en_v = 1'b0;
        cyc(1'b1, 1'(l == 0 && j < vsn), 1'(l == sp_line && j == sp_rst));
      end
    end
  endtask

  task automatic sp_clear();
    sp_line = -1; sp_vs_px = -1; sp_en_off = -1; sp_rst = -1;
  endtask

  initial begin
    model_reset();
    clr();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    vtg_ce_in = 1'b1; #1;
    check_all();
    vtg_ce_in = 1'b0; #1;
    check_all();

    // Nominal 160/40 frames with default offset; offset 200 and 5-bit saturation alongside.
    clr(); frame(10, 160, 10, 160, 40);
    chk("ll_160", 0, 32'(ll0), 32'd160);
    chk("locked_160", 0, 32'(lk_o[0]), 32'd1);
    chk("done_per_frame", 0, 32'(donec[0]), 32'd1);
    chk("low_cycles", 0, 32'(lowc[0]), 32'd4);
    chk("first_low_px", 0, 32'(first[0]), 32'd159);
    chk("first_low_line", 0, 32'(firstln[0]), 32'd8);
    chk("ofs200_first_px", 1, 32'(first[1]), 32'd1);
    chk("ofs200_done", 1, 32'(donec[1]), 32'd1);
    chk("sat_line_len", 2, 32'(ll2), 32'd31);
    chk("sat_locked", 2, 32'(lk_o[2]), 32'd1);
    clr(); frame(10, 160, 10, 160, 40);
    chk("done_frame2", 0, 32'(donec[0]), 32'd1);

    // Resolution switch 640 -> 160.
    clr(); frame(5, 640, 4, 160, 40);
    chk("switch_ll", 0, 32'(ll0), 32'd160);
    chk("switch_unlocked", 0, 32'(lk_o[0]), 32'd0);
    chk("switch_no_gate", 0, 32'(lowc[0]), 32'd0);
    clr(); frame(10, 160, 10, 160, 40);
    chk("relock_first_px", 0, 32'(first[0]), 32'd159);
    chk("relock_done", 0, 32'(donec[0]), 32'd1);

    // Enable dropped two cycles into the gate window.
    clr(); sp_line = 8; sp_en_off = 1; frame(10, 160, 10, 160, 40);
    chk("en_abort_low", 0, 32'(lowc[0]), 32'd3);
    chk("en_abort_done", 0, 32'(donec[0]), 32'd0);
    sp_clear(); en_v = 1'b1;
    clr(); frame(10, 160, 10, 160, 40);
    chk("en_recover_done", 0, 32'(donec[0]), 32'd1);

    // vsync coinciding with the trigger cycle.
    clr(); sp_line = 8; sp_vs_px = 158; frame(10, 160, 10, 160, 40);
    chk("vs_trig_low", 0, 32'(lowc[0]), 32'd0);
    chk("vs_trig_done", 0, 32'(donec[0]), 32'd0);
    sp_clear();
    clr(); frame(10, 160, 10, 160, 40);
    chk("vs_next_done", 0, 32'(donec[0]), 32'd1);
    chk("vs_next_px", 0, 32'(first[0]), 32'd159);

    // Asynchronous reset mid-gate.
    clr(); sp_line = 8; sp_rst = 1; frame(10, 160, 10, 160, 40);
    chk("rst_done", 0, 32'(donec[0]), 32'd0);
    chk("rst_one_line_ll", 0, 32'(ll0), 32'd160);
    chk("rst_one_line_unlocked", 0, 32'(lk_o[0]), 32'd0);
    sp_clear();
    clr(); frame(10, 160, 10, 160, 40);
    chk("rst_relock", 0, 32'(lk_o[0]), 32'd1);
    chk("rst_next_done", 0, 32'(donec[0]), 32'd1);

    // Randomised frames, line lengths, blanking, enables and upstream CE.
    rand_ce = 1'b1;
    for (int f = 0; f < 24; f++) begin
      int act_a, act_b;
      en_v  = 1'(($urandom % 5) != 0);
      vsn   = $urandom_range(1, 3);
      act_a = $urandom_range(4, 40);
      act_b = (($urandom % 3) == 0) ? $urandom_range(4, 40) : act_a;
      clr();
      frame($urandom_range(9, 12), act_a, $urandom_range(0, 12), act_b, $urandom_range(2, 8));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
